// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART receive encodings, parity modes and width helper.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_sync
// Brief  : Two-flop synchroniser for the serial line; resets to idle-high.
// Rev    : 1.0
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_rx,
    output logic o_rx_s
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
        end
    end

    assign o_rx_s = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_ctrl
// Brief  : Parametrised UART receiver with parity/stop/break checks and a
//          one-frame valid/ready output buffer with overrun reporting.
// Rev    : 1.0
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int TW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] C_HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] C_FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] C_DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] C_STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          C_ODD       = (PARITY_MODE == PARITY_ODD);

    logic                 w_rx_s;
    logic                 w_ferr_next;

    rx_state_e            r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_done;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_break_det;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_rx   (rx),
        .o_rx_s (w_rx_s)
    );

    // Stop-bit error including the sample being taken this tick.
    assign w_ferr_next = r_ferr | ~w_rx_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RX_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_done       <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_break_det  <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
            r_break_det <= 1'b0;

            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            // A frame finished last cycle: load it unless an unread frame blocks it.
            if (r_done) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data    <= r_shift;
                    r_parity_err <= r_perr;
                    r_frame_err  <= r_ferr;
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end

            if (tick) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!w_rx_s) begin
                            r_state    <= RX_START;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                        end
                    end
                    RX_START: begin
                        if (r_tick_cnt == C_HALF_LAST) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_perr     <= 1'b0;
                            r_ferr     <= 1'b0;
                            r_state    <= w_rx_s ? RX_IDLE : RX_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (r_tick_cnt == C_FULL_LAST) begin
                            r_tick_cnt <= '0;
                            r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == C_DATA_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY_MODE != PARITY_NONE) ? RX_PARITY : RX_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    RX_PARITY: begin
                        if (r_tick_cnt == C_FULL_LAST) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_perr     <= (^r_shift) ^ w_rx_s ^ C_ODD;
                            r_state    <= RX_STOP;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (r_tick_cnt == C_FULL_LAST) begin
                            r_tick_cnt <= '0;
                            r_ferr     <= w_ferr_next;
                            if (r_bit_cnt == C_STOP_LAST) begin
                                r_bit_cnt <= '0;
                                r_done    <= 1'b1;
                                // All-zero payload with the line still held low is a break.
                                if (w_ferr_next && (r_shift == '0) && !w_rx_s) begin
                                    r_state     <= RX_BREAK;
                                    r_break_det <= 1'b1;
                                end else begin
                                    r_state <= RX_IDLE;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    RX_BREAK: begin
                        if (w_rx_s) begin
                            r_state    <= RX_IDLE;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                        end
                    end
                    default: begin
                        r_state    <= RX_IDLE;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign break_det  = r_break_det;
    assign busy       = (r_state != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_ctrl
// Brief  : Directed, table-driven bench for uart_rx_ctrl (three parameter sets).
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_ctrl;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick = 1'b0;
    logic [2:0]       rx_l;
    logic [2:0]       rdy_a;
    logic [2:0][7:0]  data_a;
    logic [2:0]       valid_a, perr_a, ferr_a, ovr_a, brk_a, busy_a;

    int tick_div = 1;
    int tcnt     = 0;
    int cyc      = 0;
    int n_cmp    = 0;
    int n_fail   = 0;

    int         n_deliv [3] = '{0, 0, 0};
    int         n_ovr   [3] = '{0, 0, 0};
    int         n_brk   [3] = '{0, 0, 0};
    int         t_valid [3] = '{0, 0, 0};
    logic [7:0] last_data [3];
    logic       last_perr [3];
    logic       last_ferr [3];
    logic [2:0] prev_valid = 3'b000;

    typedef struct {
        logic [7:0] data;
        logic       pbit;
        logic       stopv;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tcnt >= tick_div - 1) begin
            tcnt <= 0;
            tick <= 1'b1;
        end else begin
            tcnt <= tcnt + 1;
            tick <= 1'b0;
        end
    end

    // Instance 0: even parity, 1 stop.  1: odd parity.  2: no parity, 2 stops.
    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_even (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_l[0]), .rx_ready(rdy_a[0]),
        .rx_data(data_a[0]), .rx_valid(valid_a[0]), .parity_err(perr_a[0]),
        .frame_err(ferr_a[0]), .overrun(ovr_a[0]), .break_det(brk_a[0]), .busy(busy_a[0]));

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_l[1]), .rx_ready(rdy_a[1]),
        .rx_data(data_a[1]), .rx_valid(valid_a[1]), .parity_err(perr_a[1]),
        .frame_err(ferr_a[1]), .overrun(ovr_a[1]), .break_det(brk_a[1]), .busy(busy_a[1]));

    uart_rx_ctrl #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(2)) u_stop2 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx_l[2]), .rx_ready(rdy_a[2]),
        .rx_data(data_a[2]), .rx_valid(valid_a[2]), .parity_err(perr_a[2]),
        .frame_err(ferr_a[2]), .overrun(ovr_a[2]), .break_det(brk_a[2]), .busy(busy_a[2]));

    // Records accepted frames, overrun/break pulses and rx_valid rising times.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (valid_a[k] && rdy_a[k]) begin
                n_deliv[k]   = n_deliv[k] + 1;
                last_data[k] = data_a[k];
                last_perr[k] = perr_a[k];
                last_ferr[k] = ferr_a[k];
            end
            if (valid_a[k] && !prev_valid[k]) t_valid[k] = cyc;
            if (ovr_a[k]) n_ovr[k] = n_ovr[k] + 1;
            if (brk_a[k]) n_brk[k] = n_brk[k] + 1;
            prev_valid[k] = valid_a[k];
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input int k, input logic [7:0] data, input bit par_en,
                              input logic pbit, input int nstop, input logic [1:0] stopv,
                              input int bc);
        rx_l[k] = 1'b0;
        step(bc);
        for (int i = 0; i < 8; i++) begin
            rx_l[k] = data[i];
            step(bc);
        end
        if (par_en) begin
            rx_l[k] = pbit;
            step(bc);
        end
        for (int i = 0; i < nstop; i++) begin
            rx_l[k] = stopv[i];
            step(bc);
        end
        rx_l[k] = 1'b1;
    endtask

    task automatic wait_deliv(input int k, input int base, input int budget);
        int n;
        n = 0;
        while (n_deliv[k] == base && n < budget) begin
            step(1);
            n++;
        end
        check("delivery_seen", 32'(n_deliv[k] > base), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base_o, base_b, t0, nbusy, vseen;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1};

        reset = 1'b0;
        rx_l  = 3'b111;
        rdy_a = 3'b111;
        step(3);
        check("rst_valid",  32'(valid_a[0]), 32'd0);
        check("rst_data",   32'(data_a[0]),  32'd0);
        check("rst_perr",   32'(perr_a[0]),  32'd0);
        check("rst_ferr",   32'(ferr_a[0]),  32'd0);
        check("rst_ovr",    32'(ovr_a[0]),   32'd0);
        check("rst_brk",    32'(brk_a[0]),   32'd0);
        check("rst_busy",   32'(busy_a),     32'd0);
        reset = 1'b1;
        step(5);

        // Latency: 2 sync + 1 idle-detect cycle + 168 ticks + 1 delivery cycle.
        base = n_deliv[0];
        t0   = cyc;
        send_frame(0, 8'hA5, 1'b1, 1'b0, 1, 2'b01, 16);
        wait_deliv(0, base, 200);
        check("t1_latency", 32'(t_valid[0] - t0), 32'd172);
        check("t1_data", 32'(last_data[0]), 32'hA5);
        check("t1_perr", 32'(last_perr[0]), 32'd0);
        check("t1_ferr", 32'(last_ferr[0]), 32'd0);
        step(32);

        for (int v = 0; v < 8; v++) begin
            base = n_deliv[0];
            send_frame(0, vecs[v].data, 1'b1, vecs[v].pbit, 1, {1'b1, vecs[v].stopv}, 16);
            wait_deliv(0, base, 200);
            check("vec_data", 32'(last_data[0]), 32'(vecs[v].exp_data));
            check("vec_perr", 32'(last_perr[0]), 32'(vecs[v].exp_perr));
            check("vec_ferr", 32'(last_ferr[0]), 32'(vecs[v].exp_ferr));
            step(32);
        end

        // False start: line low for 4 cycles.
        base  = n_deliv[0];
        nbusy = 0;
        vseen = 0;
        for (int i = 0; i < 48; i++) begin
            if (i == 0) rx_l[0] = 1'b0;
            if (i == 4) rx_l[0] = 1'b1;
            if (busy_a[0]) nbusy++;
            if (valid_a[0]) vseen++;
            step(1);
        end
        check("t2_busy_ticks", 32'(nbusy), 32'd8);
        check("t2_no_valid", 32'(vseen + n_deliv[0] - base), 32'd0);

        // Tick every other cycle: bit period is 32 clocks.
        tick_div = 2;
        step(4);
        base = n_deliv[0];
        send_frame(0, 8'hC3, 1'b1, 1'b0, 1, 2'b01, 32);
        wait_deliv(0, base, 400);
        check("gap_data", 32'(last_data[0]), 32'hC3);
        check("gap_perr", 32'(last_perr[0]), 32'd0);
        tick_div = 1;
        step(40);

        // Odd parity.
        base = n_deliv[1];
        send_frame(1, 8'h3C, 1'b1, 1'b0, 1, 2'b01, 16);
        wait_deliv(1, base, 200);
        check("t3_data", 32'(last_data[1]), 32'h3C);
        check("t3_perr", 32'(last_perr[1]), 32'd1);
        check("t3_ferr", 32'(last_ferr[1]), 32'd0);
        step(32);
        base = n_deliv[1];
        send_frame(1, 8'h3C, 1'b1, 1'b1, 1, 2'b01, 16);
        wait_deliv(1, base, 200);
        check("t3b_perr", 32'(last_perr[1]), 32'd0);
        step(32);

        // Two stop bits, second one low, then break and recovery.
        base   = n_deliv[2];
        base_b = n_brk[2];
        send_frame(2, 8'h12, 1'b0, 1'b0, 2, 2'b01, 16);
        wait_deliv(2, base, 200);
        check("t4_data", 32'(last_data[2]), 32'h12);
        check("t4_ferr", 32'(last_ferr[2]), 32'd1);
        step(48);
        base = n_deliv[2];
        rx_l[2] = 1'b0;
        step(40 * 16);
        check("brk_pulses", 32'(n_brk[2] - base_b), 32'd1);
        check("brk_frames", 32'(n_deliv[2] - base), 32'd1);
        check("brk_data", 32'(last_data[2]), 32'h00);
        check("brk_ferr", 32'(last_ferr[2]), 32'd1);
        check("brk_busy", 32'(busy_a[2]), 32'd1);
        rx_l[2] = 1'b1;
        step(48);
        check("brk_exit_busy", 32'(busy_a[2]), 32'd0);
        base = n_deliv[2];
        send_frame(2, 8'h55, 1'b0, 1'b0, 2, 2'b11, 16);
        wait_deliv(2, base, 200);
        check("t4_next_data", 32'(last_data[2]), 32'h55);
        check("t4_next_ferr", 32'(last_ferr[2]), 32'd0);
        check("brk_pulses_end", 32'(n_brk[2] - base_b), 32'd1);
        step(32);

        // Overrun with consumer stalled.
        rdy_a[0] = 1'b0;
        base     = n_deliv[0];
        base_o   = n_ovr[0];
        send_frame(0, 8'h11, 1'b1, 1'b0, 1, 2'b01, 16);
        step(32);
        send_frame(0, 8'h22, 1'b1, 1'b0, 1, 2'b01, 16);
        step(32);
        check("t5_valid", 32'(valid_a[0]), 32'd1);
        check("t5_data_kept", 32'(data_a[0]), 32'h11);
        check("t5_overrun", 32'(n_ovr[0] - base_o), 32'd1);
        rdy_a[0] = 1'b1;
        step(1);
        rdy_a[0] = 1'b0;
        check("t5_valid_drop", 32'(valid_a[0]), 32'd0);
        check("t5_accepted", 32'(n_deliv[0] - base), 32'd1);

        // Reset during data bit 4 with a frame held in the output register.
        send_frame(0, 8'h77, 1'b1, 1'b0, 1, 2'b01, 16);
        step(32);
        check("t6_held", 32'(valid_a[0]), 32'd1);
        rx_l[0] = 1'b0;
        step(16);
        rx_l[0] = 1'b1; step(16);
        rx_l[0] = 1'b1; step(16);
        rx_l[0] = 1'b1; step(16);
        rx_l[0] = 1'b0; step(16);
        rx_l[0] = 1'b1; step(5);
        reset = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid_a[0]), 32'd0);
        check("t6_rst_data", 32'(data_a[0]), 32'd0);
        check("t6_rst_busy", 32'(busy_a[0]), 32'd0);
        step(3);
        reset = 1'b1;
        base = n_deliv[0];
        step(8 + 16 * 5);
        rdy_a[0] = 1'b1;
        step(16);
        check("t6_no_stale", 32'(n_deliv[0] - base + 32'(valid_a[0])), 32'd0);
        send_frame(0, 8'hF0, 1'b1, 1'b0, 1, 2'b01, 16);
        wait_deliv(0, base, 200);
        check("t6_next_data", 32'(last_data[0]), 32'hF0);
        check("t6_next_perr", 32'(last_perr[0]), 32'd0);
        step(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Parametrised UART receive controller that replaces the fixed 11-bit receive FSM. It supports configurable data width, oversampling ratio, parity mode and stop-bit count. It validates the start bit, checks parity and stop bits, detects break, and buffers one frame behind a valid/ready handshake with overrun reporting. It sits between the baud-tick generator and the receive FIFO/register interface.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9, LSB first
OVERSAMPLE, 16, tick strobes per bit period, even, >=4
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked, 1 or 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick  input  1  one-cycle strobe at OVERSAMPLE x baud; all bit timing counts ticks
rx  input  1  asynchronous serial line, idle high
rx_ready  input  1  consumer accepts frame
rx_data  output  DATA_BITS  received payload, bit 0 = first bit on the line
rx_valid  output  1  frame held in output register
parity_err  output  1  parity mismatch; qualified by rx_valid
frame_err  output  1  a stop bit sampled low; qualified by rx_valid
overrun  output  1  one-cycle pulse: completed frame dropped
break_det  output  1  one-cycle pulse: break condition entered
busy  output  1  state != IDLE

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; counters cleared; sync flops set to 1; all outputs 0.
- rx passes through a 2-flop synchroniser (rx_s). The synchroniser has no other function.
- Tick counter width is clog2(OVERSAMPLE). Bit counter width is clog2(DATA_BITS+1). Both clear on every state change.
- States: IDLE, START, DATA, PARITY, STOP, BREAK (3-bit encoding).
- IDLE: on a tick with rx_s = 0, go to START.
- START: on the (OVERSAMPLE/2)th tick, sample rx_s.
  - rx_s = 1: false start; return to IDLE silently.
  - rx_s = 0: go to DATA.
- DATA: every OVERSAMPLE ticks, sample rx_s into the shift register (shift right, MSB in). After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: after OVERSAMPLE ticks, sample the parity bit.
  - perr = XOR(shift) ^ bit ^ (PARITY_MODE == 2).
  - Always continue to STOP. A parity error does not abort the frame.
- STOP: sample each stop bit at OVERSAMPLE-tick spacing. Any 0 sets ferr. After STOP_BITS samples, the frame is complete.
  - If ferr = 1, payload = 0 and the line is still low: go to BREAK.
  - Otherwise go to IDLE.
- BREAK: break_det pulses once on entry. Remain until a tick with rx_s = 1, then go to IDLE. No start is detected while in BREAK.
- Delivery happens in the cycle after the final stop sample:
  - If rx_valid = 0, or rx_ready = 1 in that cycle: load rx_data, parity_err, frame_err; rx_valid = 1.
  - Otherwise: keep the old frame, discard the new one, pulse overrun.
- Handshake: rx_valid holds with stable data until rx_valid && rx_ready. rx_valid then drops the next cycle unless a delivery occurs in the same cycle, in which case the new frame loads and rx_valid stays 1.
- A break frame is delivered like any other frame (frame_err = 1, rx_data = 0), subject to the same overrun rule.
- tick = 0 cycles: state and counters hold. Samples occur only on tick cycles.
- Latency: from the first tick seeing rx_s = 0 to rx_valid is OVERSAMPLE/2 + OVERSAMPLE x (DATA_BITS + parity + STOP_BITS) ticks, plus 1 clk.
- Reset mid-frame: the frame is abandoned. After release, the controller waits in IDLE for a fresh falling edge.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings (RX_IDLE..RX_BREAK)
  - PARITY_NONE / PARITY_EVEN / PARITY_ODD constants
  - a clog2 function used for counter widths
- One sub-module: uart_rx_sync (2-flop synchroniser, reset to 1).
- FSM, counters, shifter and output buffer stay in uart_rx_ctrl.

Test Plan:
1. DATA_BITS = 8, OVERSAMPLE = 16, PARITY_MODE = 1, tick every cycle, send 0xA5 with parity 0 and 1 stop bit, rx_ready = 1 -> rx_valid one cycle after tick 168: rx_data = 0xA5, parity_err = 0, frame_err = 0.
2. rx low for 4 ticks, then high -> busy high for 8 ticks, then low; rx_valid never asserts.
3. PARITY_MODE = 2, send 0x3C with parity bit 0 -> rx_data = 0x3C, parity_err = 1, state reaches STOP, frame still delivered.
4. STOP_BITS = 2, second stop bit low -> frame_err = 1. Then hold rx low 40 bit periods with payload 0 -> break_det single pulse, no new start until rx returns high, then next frame 0x55 received correctly.
5. rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once at the second delivery. rx_ready = 1 for one cycle -> rx_valid drops the next cycle.
6. Drive reset low during DATA bit 4 of a frame -> all outputs 0 immediately, busy = 0. After release, the remaining line bits are not delivered and the next full frame 0xF0 is received correctly.
